// File: rtl/had_sdp_serial_ctrl_if.sv
// Signal bundle between the SDP serial engine (slave) and the host/debug side (master).
// DR_W must match the DR_W of the engine it is bound to.
interface had_sdp_serial_ctrl_if #(
  parameter int DR_W = 32
);
  logic            tms_i;
  logic            tms_o;
  logic            tms_oe;
  logic            rd_req;
  logic            rd_sel;
  logic [DR_W-1:0] rd_data;
  logic            wr_ir_vld;
  logic            wr_dr_vld;
  logic [DR_W-1:0] wr_data;
  logic            parity_err;
  logic            line_rst;
  logic            busy;

  modport slave (
    input  tms_i, rd_data,
    output tms_o, tms_oe, rd_req, rd_sel, wr_ir_vld, wr_dr_vld,
           wr_data, parity_err, line_rst, busy
  );

  modport master (
    output tms_i, rd_data,
    input  tms_o, tms_oe, rd_req, rd_sel, wr_ir_vld, wr_dr_vld,
           wr_data, parity_err, line_rst, busy
  );
endinterface

// File: rtl/had_sdp_serial_ctrl.sv
// Single-wire debug (SDP) serial engine: decodes host frames on TMS, commits
// IR/DR writes, returns IR/DR reads, and reports parity errors and line resets.
module had_sdp_serial_ctrl #(
  parameter int IR_W     = 8,
  parameter int DR_W     = 32,
  parameter int TRN_CYC  = 1,
  parameter int SYNC_CNT = 80,
  parameter int PAR_ODD  = 1
) (
  input  logic                 i_tclk,
  input  logic                 i_trst,
  had_sdp_serial_ctrl_if.slave bus
);
  localparam int   CNT_W      = $clog2(DR_W + 4);
  localparam int   SYNC_W     = $clog2(SYNC_CNT + 1);
  localparam logic LP_PAR_ODD = (PAR_ODD != 0);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RW    = 4'd1,
    ST_SEL   = 4'd2,
    ST_TRN1  = 4'd3,
    ST_WDATA = 4'd4,
    ST_WPAR  = 4'd5,
    ST_RDATA = 4'd6,
    ST_RPAR  = 4'd7,
    ST_TRN2  = 4'd8
  } state_t;

  // Parity bit that goes with a data word (odd or even sense).
  function automatic logic f_par(input logic [DR_W-1:0] d);
    return (^d) ^ LP_PAR_ODD;
  endfunction

  // Keeps the low IR_W bits for IR frames, the whole word for DR frames.
  function automatic logic [DR_W-1:0] f_mask(input logic sel);
    logic [DR_W-1:0] m;
    for (int i = 0; i < DR_W; i++) begin
      m[i] = sel || (i < IR_W);
    end
    return m;
  endfunction

  state_t            r_state;
  logic              r_rw;
  logic              r_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [DR_W-1:0]   r_shift;
  logic              r_par;
  logic [SYNC_W-1:0] r_sync;
  logic              r_tms_o;
  logic              r_tms_oe;
  logic              r_rd_req;
  logic              r_wr_ir_vld;
  logic              r_wr_dr_vld;
  logic [DR_W-1:0]   r_wr_data;
  logic              r_parity_err;
  logic              r_line_rst;

  logic [CNT_W-1:0]  w_len;
  logic              w_last_trn;
  logic              w_last_bit;
  logic              w_sync_hit;
  logic [DR_W-1:0]   w_rd_word;

  assign w_len      = r_sel ? CNT_W'(DR_W) : CNT_W'(IR_W);
  assign w_last_trn = (r_cnt == CNT_W'(TRN_CYC - 1));
  assign w_last_bit = (r_cnt == (w_len - CNT_W'(1)));
  assign w_sync_hit = bus.tms_i && !r_tms_oe && (r_sync == SYNC_W'(SYNC_CNT - 1));
  assign w_rd_word  = bus.rd_data & f_mask(r_sel);

  // Frame FSM with all outputs registered; line reset overrides every transition.
  always_ff @(posedge i_tclk or posedge i_trst) begin
    if (i_trst) begin
      r_state      <= ST_IDLE;
      r_rw         <= 1'b0;
      r_sel        <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_sync       <= '0;
      r_tms_o      <= 1'b1;
      r_tms_oe     <= 1'b0;
      r_rd_req     <= 1'b0;
      r_wr_ir_vld  <= 1'b0;
      r_wr_dr_vld  <= 1'b0;
      r_wr_data    <= '0;
      r_parity_err <= 1'b0;
      r_line_rst   <= 1'b0;
    end else begin
      r_wr_ir_vld  <= 1'b0;
      r_wr_dr_vld  <= 1'b0;
      r_parity_err <= 1'b0;
      r_line_rst   <= 1'b0;
      r_tms_o      <= 1'b1;
      r_tms_oe     <= 1'b0;
      if (bus.tms_i && !r_tms_oe) begin
        r_sync <= r_sync + SYNC_W'(1);
      end else begin
        r_sync <= '0;
      end

      if (w_sync_hit) begin
        r_line_rst <= 1'b1;
        r_state    <= ST_IDLE;
        r_sync     <= '0;
        r_cnt      <= '0;
        r_rd_req   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!bus.tms_i) begin
              r_state <= ST_RW;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_RW: begin
            r_rw    <= bus.tms_i;
            r_state <= ST_SEL;
          end
          ST_SEL: begin
            r_sel    <= bus.tms_i;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_rd_req <= r_rw;
            r_state  <= ST_TRN1;
          end
          ST_TRN1: begin
            if (w_last_trn) begin
              r_cnt    <= '0;
              r_rd_req <= 1'b0;
              if (r_rw) begin
                r_shift <= w_rd_word;
                r_par   <= f_par(w_rd_word);
                r_state <= ST_RDATA;
              end else begin
                r_state <= ST_WDATA;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_WDATA: begin
            r_shift <= r_shift | (DR_W'(bus.tms_i) << r_cnt);
            if (w_last_bit) begin
              r_cnt   <= '0;
              r_state <= ST_WPAR;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_WPAR: begin
            if (bus.tms_i == f_par(r_shift)) begin
              r_wr_data   <= r_shift;
              r_wr_dr_vld <= r_sel;
              r_wr_ir_vld <= !r_sel;
            end else begin
              r_parity_err <= 1'b1;
            end
            r_cnt   <= '0;
            r_state <= ST_TRN2;
          end
          ST_RDATA: begin
            r_tms_oe <= 1'b1;
            r_tms_o  <= r_shift[0];
            r_shift  <= r_shift >> 1;
            if (w_last_bit) begin
              r_cnt   <= '0;
              r_state <= ST_RPAR;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_RPAR: begin
            r_tms_oe <= 1'b1;
            r_tms_o  <= r_par;
            r_cnt    <= '0;
            r_state  <= ST_TRN2;
          end
          ST_TRN2: begin
            if (w_last_trn) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_cnt    <= '0;
            r_rd_req <= 1'b0;
            r_state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tms_o      = r_tms_o;
  assign bus.tms_oe     = r_tms_oe;
  assign bus.rd_req     = r_rd_req;
  assign bus.rd_sel     = r_sel;
  assign bus.wr_ir_vld  = r_wr_ir_vld;
  assign bus.wr_dr_vld  = r_wr_dr_vld;
  assign bus.wr_data    = r_wr_data;
  assign bus.parity_err = r_parity_err;
  assign bus.line_rst   = r_line_rst;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule
